// File: rtl/base10_up_counter_pkg.sv
// Shared constants and the digit type for the cascaded BCD up-counter.
package base10_up_counter_pkg;
  localparam int DIGIT_W = 4;
  localparam logic [3:0] DIGIT_MAX = 4'd9;

  typedef logic [DIGIT_W-1:0] bcd_digit_t;

  // Codes 10..15 fold to 0 together with the normal 9 -> 0 wrap.
  function automatic bcd_digit_t bcd_next(input bcd_digit_t cur);
    return (cur >= DIGIT_MAX) ? bcd_digit_t'(0) : bcd_digit_t'(cur + 1'b1);
  endfunction
endpackage

// File: rtl/base10_up_counter_digit.sv
// One BCD digit: counts on ei_in, passes carry on eu_out when at 9.
// BASE10_UP_COUNTER_LOAD_EN adds a parallel load with priority over counting.
module bcd_digit_cell
  import base10_up_counter_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       ei_in,
`ifdef BASE10_UP_COUNTER_LOAD_EN
  input  logic       ld,
  input  bcd_digit_t d,
`endif
  output logic       eu_out,
  output bcd_digit_t q
);
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      q <= '0;
`ifdef BASE10_UP_COUNTER_LOAD_EN
    else if (ld)
      q <= d;
`endif
    else if (ei_in)
      q <= bcd_next(q);
  end

  // Illegal codes never equal 9, so they never propagate a carry.
  assign eu_out = ei_in & (q == DIGIT_MAX);
endmodule

// File: rtl/base10_up_counter.sv
// Cascaded DIGITS-wide BCD up-counter with enable in (ei) and carry out (eu).
// Define BASE10_UP_COUNTER_LOAD_EN to add the ld/d parallel load ports.
module base10_up_counter
  import base10_up_counter_pkg::*;
#(
  parameter int DIGITS = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      ei,
`ifdef BASE10_UP_COUNTER_LOAD_EN
  input  logic                      ld,
  input  logic [DIGIT_W*DIGITS-1:0] d,
`endif
  output logic                      eu,
  output logic [DIGIT_W*DIGITS-1:0] q3_q0
);
  logic [DIGITS:0] carry;

  assign carry[0] = ei;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    bcd_digit_cell u_cell (
      .clock  (clock),
      .reset  (reset),
      .ei_in  (carry[k]),
`ifdef BASE10_UP_COUNTER_LOAD_EN
      .ld     (ld),
      .d      (d[DIGIT_W*k +: DIGIT_W]),
`endif
      .eu_out (carry[k+1]),
      .q      (q3_q0[DIGIT_W*k +: DIGIT_W])
    );
  end

`ifdef BASE10_UP_COUNTER_LOAD_EN
  assign eu = carry[DIGITS] & ~ld;
`else
  assign eu = carry[DIGITS];
`endif
endmodule

// File: tb/tb_base10_up_counter.sv
// Directed bench: one-digit counter for basic/load behaviour, two-digit for cascade.
module tb_base10_up_counter;
  logic       clock = 1'b0;
  logic       reset1 = 1'b1, ei1 = 1'b0, eu1;
  logic [3:0] q1;
  logic       reset2 = 1'b1, ei2 = 1'b0, eu2;
  logic [7:0] q2;
`ifdef BASE10_UP_COUNTER_LOAD_EN
  logic       ld1 = 1'b0, ld2 = 1'b0;
  logic [3:0] d1 = '0;
  logic [7:0] d2 = '0;
`endif
  int tests = 0, fails = 0;

  always #5 clock = ~clock;

  base10_up_counter #(.DIGITS(1)) dut1 (
    .clock(clock), .reset(reset1), .ei(ei1),
`ifdef BASE10_UP_COUNTER_LOAD_EN
    .ld(ld1), .d(d1),
`endif
    .eu(eu1), .q3_q0(q1));

  base10_up_counter #(.DIGITS(2)) dut2 (
    .clock(clock), .reset(reset2), .ei(ei2),
`ifdef BASE10_UP_COUNTER_LOAD_EN
    .ld(ld2), .d(d2),
`endif
    .eu(eu2), .q3_q0(q2));

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset1 = 1'b1; ei1 = 1'b1;
    #2;
    tests++;
    if (q1 !== 4'd0) begin fails++; $display("FAIL reset_q got=%0h exp=0", q1); end
    tests++;
    if (eu1 !== 1'b0) begin fails++; $display("FAIL reset_eu got=%0b exp=0", eu1); end
    tick();
    tests++;
    if (q1 !== 4'd0) begin fails++; $display("FAIL reset_hold_q got=%0h exp=0", q1); end
  endtask

  task automatic test_free_run();
    int eu_hits = 0;
    reset1 = 1'b0; ei1 = 1'b1;
    for (int i = 0; i <= 20; i++) begin
      #1;
      tests++;
      if (q1 !== 4'(i % 10)) begin fails++; $display("FAIL run_q i=%0d got=%0h exp=%0h", i, q1, i % 10); end
      tests++;
      if (eu1 !== ((i % 10) == 9)) begin fails++; $display("FAIL run_eu i=%0d got=%0b exp=%0b", i, eu1, (i % 10) == 9); end
      if (eu1 === 1'b1) eu_hits++;
      if (i < 20) tick();
    end
    tests++;
    if (eu_hits != 2) begin fails++; $display("FAIL run_eu_count got=%0d exp=2", eu_hits); end
  endtask

  task automatic test_hold();
    reset1 = 1'b1; #2; reset1 = 1'b0; ei1 = 1'b1;
    repeat (5) tick();
    ei1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++;
      if (q1 !== 4'd5 || eu1 !== 1'b0) begin fails++; $display("FAIL hold5 got q=%0h eu=%0b exp q=5 eu=0", q1, eu1); end
    end
    ei1 = 1'b1;
    repeat (4) tick();
    ei1 = 1'b0;
    #1;
    tests++;
    if (q1 !== 4'd9 || eu1 !== 1'b0) begin fails++; $display("FAIL hold9 got q=%0h eu=%0b exp q=9 eu=0", q1, eu1); end
    tick();
    tests++;
    if (q1 !== 4'd9) begin fails++; $display("FAIL hold9_q got=%0h exp=9", q1); end
  endtask

  task automatic test_async_reset();
    reset1 = 1'b1; #2; reset1 = 1'b0; ei1 = 1'b1;
    repeat (7) tick();
    tests++;
    if (q1 !== 4'd7) begin fails++; $display("FAIL pre_areset got=%0h exp=7", q1); end
    #2; reset1 = 1'b1; #1;
    tests++;
    if (q1 !== 4'd0) begin fails++; $display("FAIL areset_q got=%0h exp=0", q1); end
    repeat (2) tick();
    tests++;
    if (q1 !== 4'd0 || eu1 !== 1'b0) begin fails++; $display("FAIL areset_hold got q=%0h eu=%0b exp q=0 eu=0", q1, eu1); end
    reset1 = 1'b0; ei1 = 1'b0;
  endtask

  task automatic test_cascade();
    logic [7:0] exp_q;
    reset2 = 1'b1; #2; reset2 = 1'b0; ei2 = 1'b1;
    for (int i = 0; i <= 100; i++) begin
      exp_q = {4'((i % 100) / 10), 4'(i % 10)};
      #1;
      tests++;
      if (q2 !== exp_q) begin fails++; $display("FAIL casc_q i=%0d got=%0h exp=%0h", i, q2, exp_q); end
      tests++;
      if (eu2 !== (exp_q == 8'h99)) begin fails++; $display("FAIL casc_eu i=%0d got=%0b exp=%0b", i, eu2, exp_q == 8'h99); end
      if (i < 100) tick();
    end
    ei2 = 1'b0;
  endtask

`ifdef BASE10_UP_COUNTER_LOAD_EN
  task automatic test_load();
    reset1 = 1'b1; #2; reset1 = 1'b0;
    ld1 = 1'b1; d1 = 4'd8; ei1 = 1'b0;
    tick();
    tests++;
    if (q1 !== 4'd8) begin fails++; $display("FAIL load8 got=%0h exp=8", q1); end
    d1 = 4'd12;
    tick();
    ld1 = 1'b0; ei1 = 1'b1; #1;
    tests++;
    if (q1 !== 4'd12 || eu1 !== 1'b0) begin fails++; $display("FAIL load12 got q=%0h eu=%0b exp q=c eu=0", q1, eu1); end
    tick();
    tests++;
    if (q1 !== 4'd0) begin fails++; $display("FAIL illegal_wrap got=%0h exp=0", q1); end
    ld1 = 1'b1; d1 = 4'd9; ei1 = 1'b0;
    tick();
    ei1 = 1'b1; #1;
    tests++;
    if (q1 !== 4'd9 || eu1 !== 1'b0) begin fails++; $display("FAIL ld_eu_mask got q=%0h eu=%0b exp q=9 eu=0", q1, eu1); end
    d1 = 4'd3;
    tick();
    tests++;
    if (q1 !== 4'd3) begin fails++; $display("FAIL ld_over_ei got=%0h exp=3", q1); end
    ld1 = 1'b0; ei1 = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_free_run();
    test_hold();
    test_async_reset();
    test_cascade();
`ifdef BASE10_UP_COUNTER_LOAD_EN
    test_load();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
